// File: rtl/lcd_msg_sequencer_if.sv
// Character write handshake between the message sequencer and the LCD controller.
// The master drives characters; the slave (LCD side) reports init and write completion.
interface lcd_msg_sequencer_if;
  logic [7:0] data;
  logic       writeStart;
  logic       writeDone;
  logic       initDone;

  modport master (output data, writeStart, input writeDone, initDone);
  modport slave  (input data, writeStart, output writeDone, initDone);
endinterface

// File: rtl/lcd_msg_sequencer.sv
// Streams one of NUM_MSG runtime-loaded message slots to the LCD, one character per
// write handshake, expanding 0x80..0x8F escapes into hex digits of a snapshotted value.
module lcd_msg_sequencer #(
  parameter int DEPTH   = 16,
  parameter int NUM_MSG = 4,
  parameter int VAL_W   = 16,
  parameter int AW      = 4,
  parameter int SW      = 2,
  parameter int LW      = 5
) (
  input  logic                clkFSM,
  input  logic                resetFSM,
  lcd_msg_sequencer_if.master lcd,
  input  logic                start,
  input  logic [SW-1:0]       msgSel,
  input  logic                abort,
  input  logic [VAL_W-1:0]    valIn,
  input  logic                ldEn,
  input  logic [SW-1:0]       ldMsg,
  input  logic [AW-1:0]       ldAddr,
  input  logic [7:0]          ldData,
  input  logic                lenEn,
  input  logic [LW-1:0]       ldLen,
  output logic                busy,
  output logic                done,
  output logic                ready
);

  typedef enum logic [2:0] {S_INIT, S_READY, S_SEND, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               abort_q, abort_d;
  logic [7:0]         data_q, data_d;
  logic               wstart_q, wstart_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [SW-1:0]      sel_q, sel_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic [LW-1:0]      len_q, len_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [LW-1:0]      slot_len;
  logic               last_char;
  logic               load_ok;

  logic [7:0]         mem_q [NUM_MSG][DEPTH];
  logic [LW-1:0]      len_mem_q [NUM_MSG];

  function automatic logic [7:0] decode(input logic [7:0] c, input logic [VAL_W-1:0] v);
    logic [63:0] ext;
    logic [3:0]  n;
    int          k;
    ext = 64'(v);
    k   = int'(c[3:0]);
    n   = ext[4*k +: 4];
    if (c[7:4] != 4'h8)  return c;
    if (4*k + 3 >= VAL_W) return 8'h3F;
    if (n < 4'd10)       return 8'h30 + {4'h0, n};
    return 8'h37 + {4'h0, n};
  endfunction

  // The active slot is frozen while a message is in flight.
  assign load_ok   = !(busy_q && (ldMsg == sel_q));
  assign slot_len  = len_mem_q[msgSel];
  assign last_char = (LW'(idx_q) == len_q - LW'(1));

  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    sel_d   = sel_q;
    val_d   = val_q;
    len_d   = len_q;
    idx_d   = idx_q;
    case (state_q)
      S_INIT:  if (lcd.initDone) state_d = S_READY;
      S_READY: begin
        if (start) begin
          sel_d   = msgSel;
          val_d   = valIn;
          len_d   = (slot_len > LW'(DEPTH)) ? LW'(DEPTH) : slot_len;
          idx_d   = '0;
          abort_d = 1'b0;
          state_d = (len_d == '0) ? S_DONE : S_SEND;
        end
      end
      S_SEND: begin
        if (abort) abort_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (abort) abort_d = 1'b1;
        if (lcd.writeDone) begin
          if (abort_q || abort || last_char) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_SEND;
          end
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_READY;
      end
      default: state_d = S_INIT;
    endcase

    // Outputs are registered from the next state so they never glitch on inputs.
    wstart_d = (state_d == S_SEND);
    busy_d   = (state_d == S_SEND) || (state_d == S_WAIT);
    done_d   = (state_d == S_DONE);
    ready_d  = (state_d == S_READY);
    if (state_d == S_SEND)      data_d = decode(mem_q[sel_d][idx_d], val_d);
    else if (state_d == S_WAIT) data_d = data_q;
    else                        data_d = 8'h00;
  end

  always_ff @(posedge clkFSM or posedge resetFSM) begin
    if (resetFSM) begin
      state_q  <= S_INIT;
      abort_q  <= 1'b0;
      data_q   <= 8'h00;
      wstart_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      abort_q  <= abort_d;
      data_q   <= data_d;
      wstart_q <= wstart_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge clkFSM) begin
    sel_q <= sel_d;
    val_q <= val_d;
    len_q <= len_d;
    idx_q <= idx_d;
  end

  always_ff @(posedge clkFSM or posedge resetFSM) begin
    if (resetFSM) begin
      for (int i = 0; i < NUM_MSG; i++) len_mem_q[i] <= '0;
    end else if (lenEn && load_ok) begin
      len_mem_q[ldMsg] <= ldLen;
    end
  end

  // Character storage survives reset; only the lengths decide what is sendable.
  always_ff @(posedge clkFSM) begin
    if (ldEn && load_ok) mem_q[ldMsg][ldAddr] <= ldData;
  end

  assign lcd.data       = data_q;
  assign lcd.writeStart = wstart_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign ready          = ready_q;

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Bench for lcd_msg_sequencer: an LCD responder pops a scoreboard of expected characters,
// a decode vector table, and hand-written abort/reset/busy-load sequences.
module tb_lcd_msg_sequencer;

  logic        clkFSM = 1'b0;
  logic        resetFSM;
  logic        start, abort, ldEn, lenEn;
  logic [1:0]  msgSel, ldMsg;
  logic [15:0] valIn;
  logic [3:0]  ldAddr;
  logic [7:0]  ldData;
  logic [4:0]  ldLen;
  logic        busy, done, ready;

  lcd_msg_sequencer_if lcd();

  lcd_msg_sequencer dut (
    .clkFSM(clkFSM), .resetFSM(resetFSM), .lcd(lcd.master),
    .start(start), .msgSel(msgSel), .abort(abort), .valIn(valIn),
    .ldEn(ldEn), .ldMsg(ldMsg), .ldAddr(ldAddr), .ldData(ldData),
    .lenEn(lenEn), .ldLen(ldLen),
    .busy(busy), .done(done), .ready(ready)
  );

  always #5 clkFSM = ~clkFSM;

  typedef struct {
    logic [7:0]  code;
    logic [15:0] val;
    logic [7:0]  exp;
  } dec_vec_t;

  int         checks = 0;
  int         failures = 0;
  int         ws_count = 0;
  int         done_count = 0;
  int         resp_delay = 0;
  int         last_lat = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tb_mem [4][16];
  logic [4:0] tb_len [4];

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [7:0] model_char(input logic [7:0] c, input logic [15:0] v);
    int         k;
    logic [3:0] n;
    if (c < 8'h80 || c > 8'h8F) return c;
    k = int'(c) - 128;
    if (k > 3) return 8'h3F;
    n = 4'(v >> (4 * k));
    if (n <= 4'd9) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n - 4'd10);
  endfunction

  task automatic tick();
    @(posedge clkFSM);
    #2;
  endtask

  task automatic load_char(input logic [1:0] s, input logic [3:0] a, input logic [7:0] d, input bit model);
    ldEn = 1'b1; ldMsg = s; ldAddr = a; ldData = d;
    tick();
    ldEn = 1'b0;
    if (model) tb_mem[s][a] = d;
  endtask

  task automatic load_len(input logic [1:0] s, input logic [4:0] l, input bit model);
    lenEn = 1'b1; ldMsg = s; ldLen = l;
    tick();
    lenEn = 1'b0;
    if (model) tb_len[s] = l;
  endtask

  task automatic push_model(input int s, input logic [15:0] v);
    int n;
    n = (tb_len[s] > 5'd16) ? 16 : int'(tb_len[s]);
    for (int i = 0; i < n; i++) exp_q.push_back(model_char(tb_mem[s][i], v));
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !ready; i++) tick();
    check("ready_before_start", 64'(ready), 64'd1);
  endtask

  task automatic send_msg(input int s, input logic [15:0] v, input int exp_writes, input string nm);
    int w0, d0, k;
    bit seen;
    wait_ready();
    w0 = ws_count; d0 = done_count;
    msgSel = 2'(s); valIn = v; start = 1'b1;
    tick();
    start = 1'b0; valIn = ~v;
    seen = 1'b0;
    for (k = 0; k < 2000; k++) begin
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    last_lat = k + 1;
    check({nm, "_done_seen"}, 64'(seen), 64'd1);
    tick(); tick();
    check({nm, "_writes"}, 64'(ws_count - w0), 64'(exp_writes));
    check({nm, "_done_pulses"}, 64'(done_count - d0), 64'd1);
    check({nm, "_sb_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Done pulse counter.
  initial forever begin
    @(posedge clkFSM); #1;
    if (done) done_count++;
  end

  // LCD responder: pops the scoreboard on each write, checks data holds through the wait.
  initial begin
    logic [7:0] cap;
    lcd.writeDone = 1'b0;
    forever begin
      @(posedge clkFSM); #1;
      lcd.writeDone = 1'b0;
      if (lcd.writeStart) begin
        ws_count++;
        cap = lcd.data;
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check("char_data", 64'(cap), 64'(exp_q.pop_front()));
        @(posedge clkFSM); #1;
        if (busy) begin
          check("wstart_one_cycle", 64'(lcd.writeStart), 64'd0);
          check("data_hold", 64'(lcd.data), 64'(cap));
        end
        for (int i = 0; i < resp_delay; i++) begin
          @(posedge clkFSM); #1;
          if (busy) check("data_hold", 64'(lcd.data), 64'(cap));
        end
        lcd.writeDone = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t   tbl[13];
    logic [7:0] ibm[5];
    int         w0, d0, n;
    bit         seen, wd_prev;

    tbl[0]  = '{8'h49, 16'h0000, 8'h49};
    tbl[1]  = '{8'h80, 16'hBEEF, 8'h46};
    tbl[2]  = '{8'h81, 16'hBEEF, 8'h45};
    tbl[3]  = '{8'h83, 16'hBEEF, 8'h42};
    tbl[4]  = '{8'h80, 16'h0009, 8'h39};
    tbl[5]  = '{8'h81, 16'h00A0, 8'h41};
    tbl[6]  = '{8'h82, 16'h0000, 8'h30};
    tbl[7]  = '{8'h84, 16'hBEEF, 8'h3F};
    tbl[8]  = '{8'h8F, 16'hFFFF, 8'h3F};
    tbl[9]  = '{8'h90, 16'hBEEF, 8'h90};
    tbl[10] = '{8'h7F, 16'hBEEF, 8'h7F};
    tbl[11] = '{8'h8A, 16'h1234, 8'h3F};
    tbl[12] = '{8'h83, 16'h5000, 8'h35};
    ibm = '{8'h49, 8'h42, 8'h4D, 8'h50, 8'h43};

    resetFSM = 1'b1; lcd.initDone = 1'b0;
    start = 1'b0; abort = 1'b0; ldEn = 1'b0; lenEn = 1'b0;
    msgSel = '0; ldMsg = '0; valIn = '0; ldAddr = '0; ldData = '0; ldLen = '0;
    for (int s = 0; s < 4; s++) tb_len[s] = 5'd0;
    tick(); tick();
    check("rst_data", 64'(lcd.data), 64'd0);
    check("rst_wstart", 64'(lcd.writeStart), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);
    resetFSM = 1'b0;

    // start before initDone is ignored
    d0 = done_count;
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("init_ready_low", 64'(ready), 64'd0);
    check("init_start_ignored", 64'(done_count - d0), 64'd0);
    lcd.initDone = 1'b1;
    tick();
    check("init_to_ready", 64'(ready), 64'd1);

    // plain text message
    for (int i = 0; i < 5; i++) load_char(2'd0, 4'(i), ibm[i], 1'b1);
    load_len(2'd0, 5'd5, 1'b1);
    resp_delay = 2;
    push_model(0, 16'h0);
    send_msg(0, 16'h0, 5, "ibmpc");

    // hex escapes, snapshot survives valIn change
    load_char(2'd1, 4'd0, 8'h83, 1'b1);
    load_char(2'd1, 4'd1, 8'h82, 1'b1);
    load_char(2'd1, 4'd2, 8'h81, 1'b1);
    load_char(2'd1, 4'd3, 8'h80, 1'b1);
    load_len(2'd1, 5'd4, 1'b1);
    resp_delay = 1;
    push_model(1, 16'hBEEF);
    send_msg(1, 16'hBEEF, 4, "beef");

    // decode vectors, one character each
    resp_delay = 0;
    load_len(2'd1, 5'd1, 1'b1);
    for (int i = 0; i < 13; i++) begin
      load_char(2'd1, 4'd0, tbl[i].code, 1'b1);
      exp_q.push_back(tbl[i].exp);
      send_msg(1, tbl[i].val, 1, $sformatf("dec%0d", i));
    end

    // zero-length slot: done at t+1, no writes
    load_len(2'd2, 5'd0, 1'b1);
    wait_ready();
    w0 = ws_count;
    msgSel = 2'd2; start = 1'b1; tick(); start = 1'b0;
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    check("len0_wstart", 64'(lcd.writeStart), 64'd0);
    tick();
    check("len0_ready", 64'(ready), 64'd1);
    check("len0_writes", 64'(ws_count - w0), 64'd0);

    // oversize length clamps to DEPTH; back-to-back timing is 2N+1
    for (int i = 0; i < 16; i++) load_char(2'd3, 4'(i), 8'h41 + 8'(i), 1'b1);
    load_len(2'd3, 5'd31, 1'b1);
    resp_delay = 0;
    push_model(3, 16'h0);
    send_msg(3, 16'h0, 16, "clamp");
    check("clamp_latency", 64'(last_lat), 64'd33);

    // abort during the wait of character 2 with a slow writeDone
    resp_delay = 10;
    exp_q.push_back(model_char(tb_mem[0][0], 16'h0));
    exp_q.push_back(model_char(tb_mem[0][1], 16'h0));
    wait_ready();
    w0 = ws_count; d0 = done_count;
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && n < 2; i++) begin
      if (lcd.writeStart) n++;
      if (n < 2) tick();
    end
    check("abort_second_write", 64'(n), 64'd2);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    seen = 1'b0; wd_prev = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      wd_prev = lcd.writeDone;
      tick();
    end
    check("abort_done_seen", 64'(seen), 64'd1);
    check("abort_done_after_wd", 64'(wd_prev), 64'd1);
    tick();
    check("abort_ready", 64'(ready), 64'd1);
    repeat (4) tick();
    check("abort_writes", 64'(ws_count - w0), 64'd2);
    check("abort_done_pulses", 64'(done_count - d0), 64'd1);
    check("abort_sb_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // start and loads while busy
    resp_delay = 2;
    push_model(0, 16'h0);
    wait_ready();
    w0 = ws_count; d0 = done_count;
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    tick();
    msgSel = 2'd1; start = 1'b1; tick(); start = 1'b0;
    load_char(2'd0, 4'd0, 8'h5A, 1'b0);
    load_len(2'd0, 5'd2, 1'b0);
    load_char(2'd1, 4'd0, 8'h31, 1'b1);
    check("busy_during_loads", 64'(busy), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      tick();
    end
    check("busy_done_seen", 64'(seen), 64'd1);
    tick(); tick();
    check("busy_writes", 64'(ws_count - w0), 64'd5);
    check("busy_done_pulses", 64'(done_count - d0), 64'd1);
    check("busy_sb_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    push_model(0, 16'h0);
    send_msg(0, 16'h0, 5, "resend0");
    push_model(1, 16'h0);
    send_msg(1, 16'h0, 1, "other_slot");

    // reset between writeStart and writeDone
    resp_delay = 20;
    exp_q.push_back(model_char(tb_mem[0][0], 16'h0));
    wait_ready();
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    check("rst_mid_wstart_pre", 64'(lcd.writeStart), 64'd1);
    lcd.initDone = 1'b0;
    #1 resetFSM = 1'b1;
    #1;
    check("rst_mid_wstart", 64'(lcd.writeStart), 64'd0);
    check("rst_mid_data", 64'(lcd.data), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_ready", 64'(ready), 64'd0);
    d0 = done_count;
    tick();
    resetFSM = 1'b0;
    tick();
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    tick();
    check("rst_mid_no_done", 64'(done_count - d0), 64'd0);
    check("rst_mid_init", 64'(ready), 64'd0);
    lcd.initDone = 1'b1;
    tick();
    check("rst_mid_ready_again", 64'(ready), 64'd1);
    w0 = ws_count;
    msgSel = 2'd0; start = 1'b1; tick(); start = 1'b0;
    check("rst_len_cleared_done", 64'(done), 64'd1);
    check("rst_len_cleared_busy", 64'(busy), 64'd0);
    repeat (30) tick();
    check("rst_len_cleared_writes", 64'(ws_count - w0), 64'd0);
    check("rst_sb_left", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
